// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, in-order imem request/response tracking, prefetch FIFO.
// Optional macro FETCH_PERF_COUNTERS_EN adds fetch/stall/flush performance counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] instruction_memory,
    output logic [31:0] program_counter,
    output logic        misaligned_fault
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count,
    output logic [31:0] perf_flush_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          fault_q;

    logic [31:0]   pcq_q [FIFO_DEPTH];
    logic [AW-1:0] pcq_wr_q, pcq_rd_q;

    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr_q, fifo_rd_q;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic          run, req_fire, redir, redir_ok, redir_bad, push, pop;
    logic [CW:0]   inflight;

    assign run       = (state_q == ST_RUN);
    assign inflight  = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign redir     = redirect_valid & run;
    assign redir_ok  = redir & (redirect_target[1:0] == 2'b00);
    assign redir_bad = redir & (redirect_target[1:0] != 2'b00);
    // Any accepted redirect (aligned or not) flushes the FIFO and discards this cycle's response.
    assign push      = imem_rsp_valid & (drop_q == '0) & run & ~redir;
    assign pop       = fetch_valid & fetch_ready & ~redir;

    assign imem_req_valid     = run & (inflight < DEPTH_L);
    assign imem_req_addr      = fetch_pc_q;
    assign fetch_valid        = (fifo_cnt_q != '0) & (state_q != ST_HALT);
    assign instruction_memory = fifo_data_q[fifo_rd_q];
    assign program_counter    = fifo_pc_q[fifo_rd_q];
    assign misaligned_fault   = fault_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (redir_bad) state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redir_ok)
            fetch_pc_d = redirect_target;
        else if (req_fire)
            fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // After a redirect every request still in flight (incl. one handshaking now) is stale.
    always_comb begin
        outst_d = outst_q;
        if (req_fire)       outst_d = outst_d + CW'(1);
        if (imem_rsp_valid) outst_d = outst_d - CW'(1);
        drop_d = drop_q;
        if (redir)
            drop_d = outst_d;
        else if (imem_rsp_valid && drop_q != '0)
            drop_d = drop_q - CW'(1);
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (redir)
            fifo_cnt_d = '0;
        else begin
            if (push) fifo_cnt_d = fifo_cnt_d + CW'(1);
            if (pop)  fifo_cnt_d = fifo_cnt_d - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_VECTOR;
            outst_q    <= '0;
            drop_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if (redir_bad) fault_q <= 1'b1;
        end
    end

    // Address queue pairs each in-order response with the PC that requested it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) pcq_q[i] <= '0;
            pcq_wr_q <= '0;
            pcq_rd_q <= '0;
        end else begin
            if (req_fire) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q        <= pcq_wr_q + AW'(1);
            end
            if (imem_rsp_valid) pcq_rd_q <= pcq_rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (redir) begin
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                if (push) begin
                    fifo_data_q[fifo_wr_q] <= imem_rsp_data;
                    fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
                    fifo_wr_q              <= fifo_wr_q + AW'(1);
                end
                if (pop) fifo_rd_q <= fifo_rd_q + AW'(1);
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_count <= '0;
            perf_stall_count <= '0;
            perf_flush_count <= '0;
        end else begin
            if (fetch_valid && fetch_ready)         perf_fetch_count <= perf_fetch_count + 32'd1;
            if (run && !(fetch_valid && fetch_ready)) perf_stall_count <= perf_stall_count + 32'd1;
            if (redir)                              perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end stage directly upstream of immediate_generator and the decoder.
- Owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words in a small in-order prefetch FIFO.
- Presents {instruction_memory, program_counter} pairs downstream with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing in-flight and buffered fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries; also the maximum number of outstanding memory requests (power of 2, >= 2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  word-aligned fetch address
- imem_rsp_valid  input  1  read data valid; responses return in request order, latency >= 1 cycle
- imem_rsp_data  input  32  returned instruction word
- redirect_valid  input  1  one-cycle pulse: redirect fetch
- redirect_target  input  32  new PC
- fetch_valid  output  1  instruction_memory/program_counter valid
- fetch_ready  input  1  downstream consumes the pair this cycle
- instruction_memory  output  32  instruction word (FIFO head)
- program_counter  output  32  address of instruction_memory
- misaligned_fault  output  1  sticky; redirect_target[1:0] != 0

Behaviour:
- Reset (async, asserted): state=BOOT, fetch_pc=RESET_VECTOR, FIFO empty, outstanding=0, drop=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_VECTOR, fetch_valid=0, instruction_memory=0, program_counter=0, misaligned_fault=0.
- States:
  - BOOT: one cycle, no request, then RUN.
  - RUN: normal fetch.
  - HALT: entered on misaligned redirect; exited only by rst.
- Request issue (RUN only): imem_req_valid=1 when fifo_count + outstanding < FIFO_DEPTH. imem_req_addr=fetch_pc.
  - On valid&ready: fetch_pc += 4, outstanding += 1.
  - fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Request-side PC tracking: each accepted request pushes its address into a DEPTH-entry PC queue, which is popped when the response returns.
- Response, drop==0: push {imem_rsp_data, popped addr} into FIFO, outstanding -= 1.
- Response, drop>0: discard the word, drop -= 1, outstanding -= 1.
- Output: fetch_valid = FIFO non-empty and state != HALT. Pop on fetch_valid & fetch_ready.
- Push and pop in the same cycle are allowed, including when full (pop frees the slot first) and when empty (data is visible the next cycle; no combinational rsp->fetch path).
- FIFO latency: response accepted in cycle N appears on outputs in cycle N+1.
- Redirect, RUN, aligned target, effective in the same edge:
  - FIFO flushed; a same-cycle pop is ignored.
  - fetch_pc = redirect_target.
  - drop = outstanding, minus any response arriving this cycle, which is discarded.
  - A request handshaking in the same cycle uses the old address and is counted into drop.
  - The next request issues the following cycle at the target.
- Redirect with target[1:0] != 0: misaligned_fault=1, FIFO flushed, state=HALT.
  - In HALT: no requests. Responses still decrement outstanding and are discarded.
- Redirect during BOOT or HALT: ignored.
- Reset mid-transaction: all state cleared immediately. Memory-side responses for pre-reset requests are the system's responsibility and must not arrive after reset.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- When defined, adds output ports:
  - perf_fetch_count [31:0]: increments on each fetch_valid&fetch_ready.
  - perf_stall_count [31:0]: increments each RUN cycle with fetch_valid=0, or with fetch_valid=1 and fetch_ready=0.
  - perf_flush_count [31:0]: increments per accepted redirect.
  - All three reset to 0 and wrap at 2^32.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_1000, memory latency 1, fetch_ready=1 -> first request at cycle 2 after reset release. Pairs (0x1000, mem[0x1000]), (0x1004, …) delivered back-to-back, one per cycle once streaming.
- fetch_ready=0 for 10 cycles -> exactly FIFO_DEPTH=2 requests issued, then imem_req_valid=0. Outputs hold (0x1000, word) stable. On release, order is preserved with no gaps or duplicates.
- Memory latency 3, redirect to 32'h0000_2040 while 2 requests are outstanding -> both stale responses dropped. Next delivered program_counter is 0x2040; no 0x1008/0x100C ever reaches the output.
- Redirect to 32'h0000_2042 -> misaligned_fault=1 the next cycle, fetch_valid=0, imem_req_valid=0 thereafter. Only rst clears the fault.
- Redirect in the same cycle as a response and a request handshake -> both discarded. drop is counted correctly and the first response after the redirect is for the target.
- Start at 32'hFFFF_FFF8 -> program_counter sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. With FETCH_PERF_COUNTERS_EN, perf_fetch_count=3 after three accepted pairs.
